// File: rtl/r4_divider_iter_if.sv
// Handshake and operand/result bus for r4_divider_iter.
// The master is the operand source and result consumer; the slave is the divider.
interface r4_divider_iter_if #(
    parameter int unsigned N = 12
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/r4_divider_iter.sv
// Iterative radix-4 restoring divider, 2 quotient bits per falling clock edge.
// Define R4DIV_SIGNED_EN for two's-complement operands (truncating division).
module r4_divider_iter #(
    parameter int unsigned N = 12
) (
    input logic              clk,
    input logic              rst,
    r4_divider_iter_if.slave bus
);
    localparam int unsigned W2 = N + 2;
    localparam int unsigned CW = $clog2(N / 2 + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_r, state_d;
    logic [N-1:0]    q_r, q_d;
    logic [N-1:0]    d_r, d_d;
    logic [W2-1:0]   d3_r, d3_d;
    logic [N-1:0]    r_r, r_d;
    logic [CW-1:0]   cnt_r, cnt_d;
    logic [N-1:0]    quot_r, quot_d;
    logic [N-1:0]    rem_r, rem_d;
    logic            dbz_r, dbz_d;
    logic            ov_r, ov_d;

    logic [W2-1:0]   t, d1, d2, sub;
    logic [1:0]      k;
    logic [N-1:0]    r_step, q_step, mag_a, mag_b, q_fin, r_fin;

`ifdef R4DIV_SIGNED_EN
    logic neg_q_r, neg_q_d, neg_r_r, neg_r_d;

    // Magnitudes go into the unsigned datapath; signs are reapplied on completion.
    always_comb begin
        mag_a = bus.dividend[N-1] ? N'(-bus.dividend) : bus.dividend;
        mag_b = bus.divisor[N-1]  ? N'(-bus.divisor)  : bus.divisor;
        q_fin = neg_q_r ? N'(-q_step) : q_step;
        r_fin = neg_r_r ? N'(-r_step) : r_step;
    end
`else
    assign mag_a = bus.dividend;
    assign mag_b = bus.divisor;
    assign q_fin = q_step;
    assign r_fin = r_step;
`endif

    assign bus.in_ready    = (state_r == IDLE);
    assign bus.out_valid   = ov_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;

    // One radix-4 step: pick the largest multiple of d not exceeding T.
    always_comb begin
        t  = {r_r, q_r[N-1:N-2]};
        d1 = W2'(d_r);
        d2 = W2'({d_r, 1'b0});
        if (t >= d3_r) begin
            k   = 2'd3;
            sub = d3_r;
        end else if (t >= d2) begin
            k   = 2'd2;
            sub = d2;
        end else if (t >= d1) begin
            k   = 2'd1;
            sub = d1;
        end else begin
            k   = 2'd0;
            sub = '0;
        end
        r_step = N'(t - sub);
        q_step = {q_r[N-3:0], k};
    end

    always_comb begin
        state_d = state_r;
        q_d     = q_r;
        d_d     = d_r;
        d3_d    = d3_r;
        r_d     = r_r;
        cnt_d   = cnt_r;
        quot_d  = quot_r;
        rem_d   = rem_r;
        dbz_d   = dbz_r;
        ov_d    = ov_r;
`ifdef R4DIV_SIGNED_EN
        neg_q_d = neg_q_r;
        neg_r_d = neg_r_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                        q_d     = mag_a;
                        d_d     = mag_b;
                        d3_d    = W2'(mag_b) + W2'({mag_b, 1'b0});
                        r_d     = '0;
                        cnt_d   = CW'(N / 2);
`ifdef R4DIV_SIGNED_EN
                        neg_q_d = bus.dividend[N-1] ^ bus.divisor[N-1];
                        neg_r_d = bus.dividend[N-1];
`endif
                    end
                end
            end
            BUSY: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_fin;
                    rem_d   = r_fin;
                    dbz_d   = 1'b0;
                    ov_d    = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state advances on the falling edge to line up with the multiplier pipeline.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            q_r     <= '0;
            d_r     <= '0;
            d3_r    <= '0;
            r_r     <= '0;
            cnt_r   <= '0;
            quot_r  <= '0;
            rem_r   <= '0;
            dbz_r   <= 1'b0;
            ov_r    <= 1'b0;
`ifdef R4DIV_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            state_r <= state_d;
            q_r     <= q_d;
            d_r     <= d_d;
            d3_r    <= d3_d;
            r_r     <= r_d;
            cnt_r   <= cnt_d;
            quot_r  <= quot_d;
            rem_r   <= rem_d;
            dbz_r   <= dbz_d;
            ov_r    <= ov_d;
`ifdef R4DIV_SIGNED_EN
            neg_q_r <= neg_q_d;
            neg_r_r <= neg_r_d;
`endif
        end
    end
endmodule
